mips_ex_mem_unit: RTL and testbench

Execute/memory-stage datapath block for the 5-stage MIPS pipeline. It decodes opcode/funct into a 3-bit ALU control code, performs the 32-bit ALU operation on already-forwarded operands, and contains the 1024-word data memory used by LW/SW. Pipeline registers, forwarding muxes and PC logic sit outside this block.

---
 rtl/mips_ex_mem_unit_pkg.sv | 26 ++
 rtl/mips_ex_mem_unit_dmem_array.sv | 21 ++
 rtl/mips_ex_mem_unit.sv | 69 ++++++
 tb/tb_mips_ex_mem_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mips_ex_mem_unit_pkg.sv
// mips_ex_mem_unit_pkg: opcode, funct and ALU control constants shared by
// the EX/MEM datapath and its data memory.
package mips_ex_mem_unit_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_NOR = 6'b100111;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_JR  = 6'b001000;
   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_NOR = 3'b100,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctrl_t;
endpackage

// File: rtl/mips_ex_mem_unit_dmem_array.sv
// mips_dmem_array: reset-clearable word array with synchronous write and
// asynchronous read.
module mips_dmem_array #(
   parameter int WORDS = 1024,
   parameter int AW    = 10
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [WORDS];
   always_ff @(posedge clock or posedge reset)
      if (reset)
         for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      else if (we)
         mem[addr] <= wdata;
   assign rdata = mem[addr];
endmodule

// File: rtl/mips_ex_mem_unit.sv
// mips_ex_mem_unit: EX-stage ALU control decode and ALU, plus the MEM-stage
// data memory serving LW/SW.
module mips_ex_mem_unit
   import mips_ex_mem_unit_pkg::*;
#(
   parameter int DMEM_WORDS = 1024,
   parameter int DMEM_AW    = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  ex_op,
   input  logic [5:0]  ex_funct,
   input  logic [31:0] ex_a,
   input  logic [31:0] ex_b,
   output logic [2:0]  alu_ctrl,
   output logic [31:0] alu_result,
   output logic        alu_zero,
   input  logic [5:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata
);
   alu_ctrl_t   ctrl;
   logic [31:0] word;
   logic        unused_addr_bits;
   always_comb begin
      ctrl = ALU_ADD;
      case (ex_op)
         OP_BEQ:   ctrl = ALU_SUB;
         OP_RTYPE:
            case (ex_funct)
               F_SUB:   ctrl = ALU_SUB;
               F_AND:   ctrl = ALU_AND;
               F_OR:    ctrl = ALU_OR;
               F_NOR:   ctrl = ALU_NOR;
               F_SLT:   ctrl = ALU_SLT;
               F_ADD, F_JR: ctrl = ALU_ADD;
               default: ctrl = ALU_ADD;
            endcase
         OP_LW, OP_SW, OP_ADDI, OP_J, OP_JAL: ctrl = ALU_ADD;
         default:  ctrl = ALU_ADD;
      endcase
   end
   always_comb begin
      alu_result = '0;
      case (ctrl)
         ALU_AND: alu_result = ex_a & ex_b;
         ALU_OR:  alu_result = ex_a | ex_b;
         ALU_ADD: alu_result = ex_a + ex_b;
         ALU_NOR: alu_result = ~(ex_a | ex_b);
         ALU_SUB: alu_result = ex_a - ex_b;
         ALU_SLT: alu_result = {31'b0, $signed(ex_a) < $signed(ex_b)};
         default: alu_result = '0;
      endcase
   end
   assign alu_ctrl = ctrl;
   assign alu_zero = alu_result == '0;
   // Byte offset and bits above the array are ignored, so addresses wrap.
   assign unused_addr_bits = ^{mem_addr[31:DMEM_AW+2], mem_addr[1:0]};
   mips_dmem_array #(.WORDS(DMEM_WORDS), .AW(DMEM_AW)) u_dmem (
      .clock (clock),
      .reset (reset),
      .we    (mem_op == OP_SW),
      .addr  (mem_addr[DMEM_AW+1:2]),
      .wdata (mem_wdata),
      .rdata (word)
   );
   assign mem_rdata = (mem_op == OP_LW) ? word : '0;
endmodule

// File: tb/tb_mips_ex_mem_unit.sv
// tb_mips_ex_mem_unit: scoreboard bench; stimulus pushes expected outputs,
// a negedge monitor pops and compares against the DUT.
module tb_mips_ex_mem_unit;
   logic        clock = 0, reset = 0;
   logic [5:0]  ex_op = 0, ex_funct = 0, mem_op = 0;
   logic [31:0] ex_a = 0, ex_b = 0, mem_addr = 0, mem_wdata = 0;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_result, mem_rdata;
   logic        alu_zero;
   int total = 0, bad = 0;

   typedef struct {
      logic [2:0]  ctrl;
      logic [31:0] res;
      logic        zero;
      logic [31:0] rdata;
   } exp_t;
   exp_t q[$];
   logic [31:0] model [1024];

   mips_ex_mem_unit dut (
      .clock(clock), .reset(reset), .ex_op(ex_op), .ex_funct(ex_funct),
      .ex_a(ex_a), .ex_b(ex_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
      .alu_zero(alu_zero), .mem_op(mem_op), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   function automatic logic [2:0] ref_ctrl(input logic [5:0] op, input logic [5:0] f);
      if (op == 6'b000100) return 3'b110;
      if (op != 6'b000000) return 3'b010;
      if (f == 6'b100010) return 3'b110;
      if (f == 6'b100100) return 3'b000;
      if (f == 6'b100101) return 3'b001;
      if (f == 6'b100111) return 3'b100;
      if (f == 6'b101010) return 3'b111;
      return 3'b010;
   endfunction

   function automatic logic [31:0] ref_res(input logic [5:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == 6'b000100) return a - b;
      if (op != 6'b000000) return a + b;
      if (f == 6'b100010) return a - b;
      if (f == 6'b100100) return a & b;
      if (f == 6'b100101) return a | b;
      if (f == 6'b100111) return ~(a | b);
      if (f == 6'b101010) return (sa < sb) ? 32'd1 : 32'd0;
      return a + b;
   endfunction

   function automatic int widx(input logic [31:0] addr);
      return int'((addr / 4) % 1024);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clock)
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         check("alu_ctrl", {29'b0, alu_ctrl}, {29'b0, e.ctrl});
         check("alu_result", alu_result, e.res);
         check("alu_zero", {31'b0, alu_zero}, {31'b0, e.zero});
         check("mem_rdata", mem_rdata, e.rdata);
      end

   // Called just after a rising edge; leaves time just after the next one.
   task automatic step(input logic [5:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] mop, input logic [31:0] addr,
                       input logic [31:0] wd);
      exp_t e;
      ex_op = op; ex_funct = f; ex_a = a; ex_b = b;
      mem_op = mop; mem_addr = addr; mem_wdata = wd;
      if (reset) for (int i = 0; i < 1024; i++) model[i] = 0;
      e.ctrl  = ref_ctrl(op, f);
      e.res   = ref_res(op, f, a, b);
      e.zero  = (e.res == 0);
      e.rdata = (mop == 6'b100011) ? model[widx(addr)] : 32'd0;
      q.push_back(e);
      if (mop == 6'b101011 && !reset) model[widx(addr)] = wd;
      @(posedge clock);
      #1;
   endtask

   localparam logic [5:0] R = 6'b000000, BEQ = 6'b000100, ADDI = 6'b001000,
                          LW = 6'b100011, SW = 6'b101011, J = 6'b000010;

   initial begin
      logic [5:0] ops [8];
      logic [5:0] fns [8];
      for (int i = 0; i < 1024; i++) model[i] = 0;
      ops = '{R, R, R, BEQ, ADDI, LW, SW, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b001000, 6'b010101};
      reset = 1;
      @(posedge clock); #1;
      step(R, 6'b100000, 7, 5, LW, 32'h10, 0);
      reset = 0;
      step(R, 6'b100000, 7, 5, LW, 32'h10, 0);
      step(R, 6'b100010, 7, 5, J, 0, 0);
      step(BEQ, 0, 32'h1234, 32'h1234, 0, 0, 0);
      step(ADDI, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
      step(R, 6'b101010, 32'hFFFFFFFE, 1, 0, 0, 0);
      step(R, 6'b101010, 1, 32'hFFFFFFFE, 0, 0, 0);
      step(R, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0);
      step(R, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0);
      step(R, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0);
      step(R, 6'b001000, 3, 4, SW, 32'h10, 32'hDEADBEEF);
      step(J, 0, 1, 2, LW, 32'h10, 0);
      step(6'b000011, 0, 1, 2, LW, 32'h13, 0);
      step(6'b111111, 0, 1, 2, LW, 32'h1010, 0);
      step(R, 6'b010101, 9, 9, BEQ, 32'h10, 32'h5555);
      step(R, 0, 0, 0, LW, 32'h10, 0);
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, b, ad;
         logic [5:0] mop;
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         ad = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) ad = ad | ($urandom << 12);
         mop = ops[$urandom_range(3, 7)];
         step(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 7)], a, b, mop, ad, $urandom);
      end
      step(R, 0, 1, 1, SW, 32'h20, 32'hCAFEF00D);
      step(R, 0, 1, 1, LW, 32'h20, 0);
      reset = 1;
      step(R, 0, 1, 1, SW, 32'h24, 32'h12345678);
      reset = 0;
      step(R, 0, 1, 1, LW, 32'h10, 0);
      step(R, 0, 1, 1, LW, 32'h20, 0);
      step(R, 0, 1, 1, LW, 32'h24, 0);
      for (int i = 0; i < 64; i++) step(R, 0, i, 0, LW, i * 4, 0);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clock);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
